mine_placer: RTL and testbench

MINE_PLACER -- requirements
Module: mine_placer

---
 rtl/mine_placer.sv | 136 +++++++++++++
 tb/tb_mine_placer.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/mine_placer.sv
// Places a requested number of mines on a 2^GRID_BITS cell board from a stream of
// random bytes, never on the first-clicked cell, giving up after MAX_TRIES draws.
module mine_placer #(
  parameter int GRID_BITS = 6,
  parameter int MAX_TRIES = 1023
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic [GRID_BITS-1:0]        mine_count,
  input  logic [GRID_BITS-1:0]        safe_cell,
  input  logic [7:0]                  rnd,
  input  logic                        rnd_valid,
  output logic [(1<<GRID_BITS)-1:0]   mine_map,
  output logic [GRID_BITS-1:0]        placed,
  output logic                        busy,
  output logic                        done,
  output logic                        fail
);

  localparam int CELLS = 1 << GRID_BITS;
  localparam int TRY_W = $clog2(MAX_TRIES + 1);
  localparam logic [GRID_BITS-1:0] MAX_TARGET = GRID_BITS'(CELLS - 1);
  localparam logic [TRY_W-1:0]     TRY_LIMIT  = TRY_W'(MAX_TRIES);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PLACE = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t               state_reg,  state_next;
  logic [CELLS-1:0]     map_reg,    map_next;
  logic [GRID_BITS-1:0] placed_reg, placed_next;
  logic [GRID_BITS-1:0] target_reg, target_next;
  logic [GRID_BITS-1:0] safe_reg,   safe_next;
  logic [TRY_W-1:0]     tries_reg,  tries_next;
  logic                 fail_reg,   fail_next;

  logic [GRID_BITS-1:0] idx;
  logic [CELLS-1:0]     idx_onehot;
  logic                 draw_ok;
  logic [GRID_BITS-1:0] placed_inc;
  logic [TRY_W-1:0]     tries_inc;

  // Only the low GRID_BITS of the random byte select a cell.
  assign idx = rnd[GRID_BITS-1:0];

  generate
    if (GRID_BITS < 8) begin : g_rnd_hi
      logic unused_rnd_hi;
      assign unused_rnd_hi = ^rnd[7:GRID_BITS];
    end
  endgenerate

  for (genvar gi = 0; gi < CELLS; gi++) begin : g_dec
    assign idx_onehot[gi] = (idx == GRID_BITS'(gi));
  end

  // A draw lands only on a cell that is neither the safe cell nor already mined.
  assign draw_ok    = (idx != safe_reg) && ((map_reg & idx_onehot) == '0);
  assign placed_inc = draw_ok ? placed_reg + GRID_BITS'(1) : placed_reg;
  assign tries_inc  = tries_reg + TRY_W'(1);

  always_comb begin
    state_next  = state_reg;
    map_next    = map_reg;
    placed_next = placed_reg;
    target_next = target_reg;
    safe_next   = safe_reg;
    tries_next  = tries_reg;
    fail_next   = fail_reg;
    unique case (state_reg)
      IDLE: begin
        if (start) begin
          state_next  = PLACE;
          safe_next   = safe_cell;
          target_next = (mine_count > MAX_TARGET) ? MAX_TARGET : mine_count;
          map_next    = '0;
          placed_next = '0;
          tries_next  = '0;
          fail_next   = 1'b0;
        end
      end
      PLACE: begin
        // Completion is checked before any draw, so a satisfied run never draws again.
        if (placed_reg == target_reg) begin
          state_next = DONE;
        end else if (rnd_valid) begin
          tries_next  = tries_inc;
          placed_next = placed_inc;
          if (draw_ok) begin
            map_next = map_reg | idx_onehot;
          end
          if ((tries_inc == TRY_LIMIT) && (placed_inc != target_reg)) begin
            state_next = DONE;
            fail_next  = 1'b1;
          end
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg  <= IDLE;
      map_reg    <= '0;
      placed_reg <= '0;
      target_reg <= '0;
      safe_reg   <= '0;
      tries_reg  <= '0;
      fail_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      map_reg    <= map_next;
      placed_reg <= placed_next;
      target_reg <= target_next;
      safe_reg   <= safe_next;
      tries_reg  <= tries_next;
      fail_reg   <= fail_next;
    end
  end

  assign mine_map = map_reg;
  assign placed   = placed_reg;
  assign busy     = (state_reg == PLACE);
  assign done     = (state_reg == DONE);
  assign fail     = fail_reg;

endmodule

// File: tb/tb_mine_placer.sv
// Directed and randomized checks of mine_placer against a stream-level placement model.
module tb_mine_placer;

  localparam int GB    = 6;
  localparam int CELLS = 64;
  localparam int MAXT  = 1023;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [5:0]  mine_count = '0;
  logic [5:0]  safe_cell = '0;
  logic [7:0]  rnd = '0;
  logic        rnd_valid = 1'b0;
  logic [63:0] mine_map;
  logic [5:0]  placed;
  logic        busy;
  logic        done;
  logic        fail;

  int total = 0;
  int bad = 0;
  int s_val[$];
  bit s_vld[$];
  int trace[4096];

  mine_placer #(.GRID_BITS(GB), .MAX_TRIES(MAXT)) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .mine_count(mine_count),
    .safe_cell(safe_cell),
    .rnd(rnd),
    .rnd_valid(rnd_valid),
    .mine_map(mine_map),
    .placed(placed),
    .busy(busy),
    .done(done),
    .fail(fail)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // The model walks the input stream one slot per PLACE cycle: a finished run uses one
  // extra slot to notice completion; a run that exhausts its tries ends on that draw.
  task automatic run_case(input string name, input int mc, input int sc, input bit spam);
    logic [63:0] emap;
    int target, p, tries, ecyc, got, idx;
    bit efail, v;
    emap = '0; p = 0; tries = 0; ecyc = -1; got = -1; efail = 1'b0;
    target = (mc > CELLS - 1) ? CELLS - 1 : mc;
    for (int i = 0; i < 4000; i++) begin
      v = (i < s_val.size()) ? s_vld[i] : 1'b0;
      if (p == target) begin
        trace[i] = p;
        ecyc = i + 1;
        break;
      end
      if (v) begin
        tries++;
        idx = s_val[i] % CELLS;
        if (idx != sc && !emap[idx]) begin
          emap[idx] = 1'b1;
          p++;
        end
      end
      trace[i] = p;
      if (v && tries == MAXT && p < target) begin
        efail = 1'b1;
        ecyc = i + 1;
        break;
      end
    end

    @(negedge clk);
    start = 1'b1;
    mine_count = mc[5:0];
    safe_cell = sc[5:0];
    rnd_valid = 1'b0;
    @(posedge clk);
    #1;
    check({name, " busy_after_start"}, {63'd0, busy}, 64'd1);
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      start = spam ? 1'($urandom_range(1)) : 1'b0;
      if (spam) begin
        mine_count = 6'($urandom);
        safe_cell = 6'($urandom);
      end
      rnd = (i < s_val.size()) ? 8'(s_val[i]) : 8'($urandom);
      rnd_valid = (i < s_val.size()) ? s_vld[i] : 1'b0;
      @(posedge clk);
      #1;
      if (i < ecyc) check({name, " placed_trace"}, {58'd0, placed}, 64'(trace[i]));
      if (done) begin
        got = i + 1;
        break;
      end
    end
    check({name, " done_latency"}, 64'(got), 64'(ecyc));
    check({name, " mine_map"}, mine_map, emap);
    check({name, " placed"}, {58'd0, placed}, 64'(p));
    check({name, " fail"}, {63'd0, fail}, {63'd0, efail});
    check({name, " busy_in_done"}, {63'd0, busy}, 64'd0);
    check({name, " safe_clear"}, {63'd0, mine_map[sc]}, 64'd0);

    @(negedge clk);
    start = spam;
    rnd = 8'($urandom);
    rnd_valid = 1'b1;
    @(posedge clk);
    #1;
    check({name, " done_one_cycle"}, {63'd0, done}, 64'd0);
    check({name, " idle_not_busy"}, {63'd0, busy}, 64'd0);
    check({name, " map_held"}, mine_map, emap);
    @(negedge clk);
    start = 1'b0;
    rnd_valid = 1'b0;
    $display("case %s: mines=%0d safe=%0d placed=%0d fail=%0b done_after=%0d",
             name, mc, sc, placed, fail, got);
  endtask

  task automatic clear_stream();
    s_val.delete();
    s_vld.delete();
  endtask

  initial begin
    logic [7:0] lfsr;
    int base[5];

    #2 reset = 1'b0;
    #1;
    check("reset map", mine_map, 64'd0);
    check("reset placed", {58'd0, placed}, 64'd0);
    check("reset busy", {63'd0, busy}, 64'd0);
    check("reset done", {63'd0, done}, 64'd0);
    check("reset fail", {63'd0, fail}, 64'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;

    // Duplicate and safe-cell draws are rejected.
    clear_stream();
    base = '{5, 5, 0, 9, 12};
    foreach (base[k]) begin s_val.push_back(base[k]); s_vld.push_back(1'b1); end
    run_case("basic", 3, 0, 1'b0);

    // Same draws with gaps and start pulses in flight; upper rnd bits set.
    clear_stream();
    foreach (base[k]) begin
      s_val.push_back(base[k] + 64 * int'($urandom_range(3))); s_vld.push_back(1'b1);
      s_val.push_back(int'($urandom_range(255))); s_vld.push_back(1'b0);
    end
    run_case("gated", 3, 0, 1'b1);

    clear_stream();
    for (int k = 0; k < 8; k++) begin s_val.push_back(int'($urandom_range(255))); s_vld.push_back(1'b1); end
    run_case("zero", 0, 10, 1'b0);

    clear_stream();
    lfsr = 8'h01;
    for (int k = 0; k < 1000; k++) begin
      s_val.push_back(int'(lfsr)); s_vld.push_back(1'b1);
      lfsr = lfsr[0] ? ((lfsr >> 1) ^ 8'hB8) : (lfsr >> 1);
    end
    run_case("full", 63, 7, 1'b0);

    clear_stream();
    for (int k = 0; k < 1100; k++) begin s_val.push_back(3); s_vld.push_back(1'b1); end
    run_case("exhaust", 2, 0, 1'b0);

    clear_stream();
    for (int k = 0; k < 2200; k++) begin
      s_val.push_back((k % 2 == 0) ? 3 : 40); s_vld.push_back(k % 2 == 0);
    end
    run_case("exhaust_gated", 2, 0, 1'b1);

    for (int r = 0; r < 3; r++) begin
      clear_stream();
      for (int k = 0; k < 600; k++) begin
        s_val.push_back(int'($urandom_range(255)));
        s_vld.push_back($urandom_range(9) < 7);
      end
      run_case("random", int'($urandom_range(40, 1)), int'($urandom_range(63)), r[0]);
    end

    // Abort mid-placement with an asynchronous reset.
    @(negedge clk);
    start = 1'b1; mine_count = 6'd5; safe_cell = 6'd0;
    @(negedge clk);
    start = 1'b0; rnd = 8'd10; rnd_valid = 1'b1;
    @(negedge clk);
    rnd = 8'd20;
    @(negedge clk);
    rnd_valid = 1'b0;
    @(posedge clk);
    #1;
    check("abort placed_before", {58'd0, placed}, 64'd2);
    check("abort busy_before", {63'd0, busy}, 64'd1);
    #2 reset = 1'b0;
    #1;
    check("abort map", mine_map, 64'd0);
    check("abort placed", {58'd0, placed}, 64'd0);
    check("abort busy", {63'd0, busy}, 64'd0);
    check("abort fail", {63'd0, fail}, 64'd0);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      check("abort no_done", {63'd0, done}, 64'd0);
    end
    @(negedge clk);
    reset = 1'b1;
    $display("case abort: reset during placement");

    clear_stream();
    for (int k = 0; k < 400; k++) begin s_val.push_back(int'($urandom_range(255))); s_vld.push_back(1'b1); end
    run_case("after_reset", 5, 33, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
